// File: rtl/datasaver_fifo.sv
// datasaver_fifo: edge-triggered capture of data_i into a first-word-fall-through
// FIFO. Each 0->1 transition of saveflag queues one word; rd_en pops the head.
// Occupancy, full and a sticky overflow flag are reported. All state is reset
// synchronously by rst, including the storage array.
module datasaver_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           saveflag,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           rd_en,
    input  logic                           clr_ovf,
    output logic [WIDTH-1:0]               data_o,
    output logic                           valid,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             sf_dly_q;

    logic             rise_s;
    logic             valid_s;
    logic             full_s;
    logic             rd_eff_s;
    logic             wr_s;
    logic             drop_s;

    // Strobe edge detect and the write/pop/drop qualifiers, all from registered state.
    always_comb begin
        rise_s   = saveflag & ~sf_dly_q;
        valid_s  = (count_q != {CW{1'b0}});
        full_s   = (count_q == DEPTH_C);
        rd_eff_s = rd_en & valid_s;
        wr_s     = rise_s & (~full_s | rd_eff_s);
        drop_s   = rise_s & full_s & ~rd_eff_s;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_eff_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_s, rd_eff_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as clr_ovf keeps the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers; the strobe history resets high so a strobe held
    // through reset release is not mistaken for a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
            sf_dly_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            sf_dly_q <= saveflag;
        end
    end

    // Storage array: cleared on reset, written at the write pointer on a capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Outputs are taken directly from registered state (head word is fall-through).
    always_comb begin
        data_o   = mem_q[rd_ptr_q];
        valid    = valid_s;
        full     = full_s;
        count    = count_q;
        overflow = ovf_q;
    end

endmodule
